clk_div_prog: RTL and testbench

Programmable integer clock divider and clock-enable generator. It replaces the fixed divide-by-2 pixel-clock generator with a runtime-selectable ratio N. It produces a registered divided clock level, `clk_out`, and a one-cycle `tick` enable at the start of every output period. Ratio changes take effect only at period boundaries, so VGA timing and peripheral logic never see a runt period.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_shadow.sv | 48 ++++
 rtl/clk_div_prog.sv | 94 +++++++++
 tb/tb_clk_div_prog.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_W_DEF       = 8;
  localparam int CLK_DIV_DEFAULT_DEF = 2;

  // High-phase length of an N-cycle period: ceil(N/2)
  function automatic logic [31:0] high_phase(input logic [31:0] n);
    return (n + 32'd1) >> 5'd1;
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow ratio register: validates loads, keeps the last accepted ratio
// until the divider consumes it at a period boundary.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int DIV_W = CLK_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             apply,
  output logic [DIV_W-1:0] pend_val,
  output logic             pend_vld,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};

  logic load_ok_s;
  logic load_bad_s;

  // Classify the incoming load request
  always_comb begin
    load_ok_s  = div_load & (div_val != ZERO);
    load_bad_s = div_load & (div_val == ZERO);
  end

  // A fresh load beats a same-cycle apply, so the new value waits for the next boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= ZERO;
      pend_vld <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= load_bad_s;
      if (load_ok_s) begin
        pend_val <= div_val;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end else begin
        pend_vld <= pend_vld;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with tick enable; ratio changes are
// deferred to period boundaries so no runt period is ever produced.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = CLK_DIV_W_DEF,
  parameter int DEFAULT_DIV = CLK_DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] n_act_r;
  logic             running_r;

  logic [DIV_W-1:0] pend_val_s;
  logic             pend_vld_s;
  logic             apply_s;
  logic             wrap_s;
  logic [DIV_W-1:0] cnt_next_s;
  logic [DIV_W-1:0] n_next_s;
  logic [31:0]      h_s;

  clk_div_shadow #(
    .DIV_W (DIV_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .div_val  (div_val),
    .div_load (div_load),
    .apply    (apply_s),
    .pend_val (pend_val_s),
    .pend_vld (pend_vld_s),
    .div_err  (div_err)
  );

  // Next phase, ratio swap decision and high-phase length for the next cycle
  always_comb begin
    apply_s    = 1'b0;
    cnt_next_s = cnt_r;
    wrap_s     = (cnt_r == (n_act_r - ONE));
    if (!en) begin
      apply_s    = 1'b0;
      cnt_next_s = cnt_r;
    end else if (!running_r) begin
      apply_s    = pend_vld_s;
      cnt_next_s = ZERO;
    end else begin
      apply_s    = wrap_s & pend_vld_s;
      cnt_next_s = wrap_s ? ZERO : (cnt_r + ONE);
    end
    n_next_s = apply_s ? pend_val_s : n_act_r;
    h_s      = high_phase(32'(n_next_s));
  end

  // Counter, active ratio and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= ZERO;
      n_act_r   <= DEF_DIV;
      running_r <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      div_ack   <= 1'b0;
    end else begin
      n_act_r <= n_next_s;
      div_ack <= apply_s;
      if (en) begin
        cnt_r     <= cnt_next_s;
        running_r <= 1'b1;
        clk_out   <= (32'(cnt_next_s) < h_s);
        tick      <= (cnt_next_s == ZERO);
      end else begin
        cnt_r     <= cnt_r;
        running_r <= 1'b0;
        clk_out   <= 1'b0;
        tick      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic       div_ack;
  logic       div_err;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_ack  (div_ack),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_val = 8'd0; div_load = 1'b0;
    cyc(); cyc();
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      $display("FAIL reset_state got=%b exp=0000", {clk_out, tick, div_ack, div_err}); errors++;
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      $display("FAIL idle_state got=%b exp=0000", {clk_out, tick, div_ack, div_err}); errors++;
    end
  endtask

  task automatic test_div2();
    logic [0:6] ec, et;
    ec = 7'b1010101; et = 7'b1010101;
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack} !== {ec[i], et[i], 1'b0}) begin
        $display("FAIL div2_wave cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack}, {ec[i], et[i], 1'b0});
        errors++;
      end
    end
  endtask

  task automatic test_load5();
    logic [0:9] ec, et, ea;
    ec = 10'b1110011100; et = 10'b1000010000; ea = 10'b1000000000;
    div_val = 8'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b000) begin
      $display("FAIL load5_finish_period got=%b exp=000", {clk_out, tick, div_ack}); errors++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack} !== {ec[i], et[i], ea[i]}) begin
        $display("FAIL load5_wave cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack}, {ec[i], et[i], ea[i]});
        errors++;
      end
    end
  endtask

  task automatic test_err();
    logic [0:3] ec;
    ec = 4'b1100;
    div_val = 8'd0; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b1101) begin
      $display("FAIL err_pulse got=%b exp=1101", {clk_out, tick, div_ack, div_err}); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack, div_err} !== {ec[i], 3'b000}) begin
        $display("FAIL err_after cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack, div_err}, {ec[i], 3'b000});
        errors++;
      end
    end
  endtask

  task automatic test_last_writer();
    logic [0:11] ec, et, ea;
    int acks;
    ec = 12'b110011110001; et = 12'b000010000001; ea = 12'b000010000000;
    acks = 0;
    div_val = 8'd3; div_load = 1'b1;
    cyc();
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b110) begin
      $display("FAIL load_at_boundary got=%b exp=110", {clk_out, tick, div_ack}); errors++;
    end
    div_val = 8'd7;
    for (int i = 0; i < 12; i++) begin
      cyc();
      div_load = 1'b0;
      if (div_ack === 1'b1) acks++;
      checks++;
      if ({clk_out, tick, div_ack} !== {ec[i], et[i], ea[i]}) begin
        $display("FAIL lastwr_wave cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack}, {ec[i], et[i], ea[i]});
        errors++;
      end
    end
    checks++;
    if (acks !== 1) begin
      $display("FAIL lastwr_ack_count got=%0d exp=1", acks); errors++;
    end
  endtask

  task automatic test_n1();
    div_val = 8'd1; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b100) begin
      $display("FAIL n1_pending got=%b exp=100", {clk_out, tick, div_ack}); errors++;
    end
    repeat (5) cyc();
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b000) begin
      $display("FAIL n1_last_low got=%b exp=000", {clk_out, tick, div_ack}); errors++;
    end
    cyc();
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b111) begin
      $display("FAIL n1_apply got=%b exp=111", {clk_out, tick, div_ack}); errors++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack} !== 3'b110) begin
        $display("FAIL n1_steady cyc=%0d got=%b exp=110", i, {clk_out, tick, div_ack}); errors++;
      end
    end
  endtask

  task automatic test_en_drop();
    logic [0:4] ec, et, ea;
    logic [2:0] exp_seq [6];
    ec = 5'b11001; et = 5'b10001; ea = 5'b10000;
    exp_seq[0] = 3'b110; exp_seq[1] = 3'b111; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b100; exp_seq[4] = 3'b000; exp_seq[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      div_load = (i == 0) || (i == 2);
      div_val  = (i == 0) ? 8'd5 : 8'd4;
      en       = (i < 4);
      cyc();
      div_load = 1'b0;
      checks++;
      if ({clk_out, tick, div_ack} !== exp_seq[i]) begin
        $display("FAIL endrop_seq step=%0d got=%b exp=%b", i, {clk_out, tick, div_ack}, exp_seq[i]);
        errors++;
      end
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack} !== {ec[i], et[i], ea[i]}) begin
        $display("FAIL restart_wave cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack}, {ec[i], et[i], ea[i]});
        errors++;
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [0:5] ec;
    ec = 6'b101010;
    cyc();
    checks++;
    if ({clk_out, tick, div_ack} !== 3'b100) begin
      $display("FAIL prerst got=%b exp=100", {clk_out, tick, div_ack}); errors++;
    end
    rst = 1'b1; div_val = 8'd9; div_load = 1'b1;
    cyc();
    rst = 1'b0; div_load = 1'b0;
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      $display("FAIL midrst_outputs got=%b exp=0000", {clk_out, tick, div_ack, div_err}); errors++;
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if ({clk_out, tick, div_ack, div_err} !== {ec[i], ec[i], 2'b00}) begin
        $display("FAIL postrst_div2 cyc=%0d got=%b exp=%b", i, {clk_out, tick, div_ack, div_err}, {ec[i], ec[i], 2'b00});
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_load5();
    test_err();
    test_last_writer();
    test_n1();
    test_en_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
